// File: rtl/dmem_word_arbiter.sv
// Word-to-byte bridge sharing a byte-wide data memory between a CPU port and a debug port.
// Each word access is four big-endian byte accesses; CPU has priority, debug has an anti-starvation escape.
module dmem_word_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_ack_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [31:0]   dbg_wdata_i,
  output logic [31:0]   dbg_rdata_o,
  output logic          dbg_ack_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i,
  output logic          busy_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, XFER, CAPT, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          gnt_dbg_q, gnt_dbg_d;
  logic          we_q, we_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          sel_dbg;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      gnt_dbg_q   <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      shift_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      gnt_dbg_q   <= gnt_dbg_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; outputs are precomputed from the next state so they line up with it
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    gnt_dbg_d   = gnt_dbg_q;
    we_d        = we_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    sel_dbg     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          sel_dbg   = dbg_req_i && (!cpu_req_i || (starve_q == SW'(STARVE_LIMIT)));
          gnt_dbg_d = sel_dbg;
          we_d      = sel_dbg ? dbg_we_i : cpu_we_i;
          base_d    = (sel_dbg ? dbg_addr_i : cpu_addr_i) & ~AW'(3);
          wdata_d   = sel_dbg ? dbg_wdata_i : cpu_wdata_i;
          cnt_d     = 2'd0;
          state_d   = XFER;
          if (sel_dbg) begin
            starve_d = '0;
          end else if (dbg_req_i && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      XFER: begin
        // Synchronous memory: the byte issued last cycle is on mem_rdata_i now
        if ((cnt_q != 2'd0) && !we_q) begin
          shift_d = {shift_q[15:0], mem_rdata_i};
        end
        if (cnt_q == 2'd3) begin
          state_d = CAPT;
        end
        cnt_d = cnt_q + 2'd1;
      end
      CAPT: begin
        if (!we_q) begin
          if (gnt_dbg_q) begin
            dbg_rdata_d = {shift_q, mem_rdata_i};
          end else begin
            cpu_rdata_d = {shift_q, mem_rdata_i};
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_en_d   = (state_d == XFER);
    mem_we_d   = (state_d == XFER) && we_d;
    mem_addr_d = (state_d == XFER) ? (base_d + AW'(cnt_d)) : '0;
    unique case (cnt_d)
      2'd0:    mem_wdata_d = wdata_d[31:24];
      2'd1:    mem_wdata_d = wdata_d[23:16];
      2'd2:    mem_wdata_d = wdata_d[15:8];
      default: mem_wdata_d = wdata_d[7:0];
    endcase
    if (state_d != XFER) begin
      mem_wdata_d = '0;
    end
    cpu_ack_d = (state_d == DONE) && !gnt_dbg_d;
    dbg_ack_d = (state_d == DONE) && gnt_dbg_d;
    busy_d    = (state_d != IDLE);
  end

  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign dbg_ack_o   = dbg_ack_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule
